// File: rtl/herald_pkg.sv
// Shared definitions for the herald coprocessor arbiter: command codes,
// command legality check and the arbiter state encoding.
package herald_pkg;

  localparam logic [7:0] CMD_CORDIC_ROT  = 8'h10;
  localparam logic [7:0] CMD_CORDIC_VEC  = 8'h11;
  localparam logic [7:0] CMD_CORDIC_SIN  = 8'h12;
  localparam logic [7:0] CMD_CORDIC_NORM = 8'h13;
  localparam logic [7:0] CMD_MAC_MUL     = 8'h20;
  localparam logic [7:0] CMD_MAC_ACC     = 8'h21;
  localparam logic [7:0] CMD_MAC_CLR     = 8'h22;
  localparam logic [7:0] CMD_MAC_DOT     = 8'h23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  function automatic logic is_legal_cmd(input logic [7:0] cmd);
    return ((cmd >= CMD_CORDIC_ROT) && (cmd <= CMD_CORDIC_NORM)) ||
           ((cmd >= CMD_MAC_MUL) && (cmd <= CMD_MAC_DOT));
  endfunction

endpackage

// File: rtl/herald_rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// searching upward from the slot after the last grant, wrapping around.
module herald_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic             any_o,
  output logic [IDX_W-1:0] grant_o
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    any_o   = 1'b0;
    grant_o = '0;
    idx     = 0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = (int'(last_grant_i) + off) % N_REQ;
      if (req_i[idx]) begin
        any_o   = 1'b1;
        grant_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/herald_coproc_arbiter.sv
// Round-robin arbiter sharing one CORDIC/MAC engine between N_REQ requesters,
// sequencing start/done, rejecting illegal commands and timing out hung ops.
module herald_coproc_arbiter
  import herald_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 24,
  parameter int RES_W   = 72,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [8*N_REQ-1:0]      req_cmd,
  input  logic [DATA_W*N_REQ-1:0] req_a,
  input  logic [DATA_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]        req_ack,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [RES_W-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    eng_start,
  output logic [7:0]              eng_cmd,
  output logic [DATA_W-1:0]       eng_a,
  output logic [DATA_W-1:0]       eng_b,
  input  logic                    eng_done,
  input  logic [RES_W-1:0]        eng_result,
  output logic                    busy
);

  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                start_q, start_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]    rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic                pick_any;
  logic [IDX_W-1:0]    pick_grant;
  logic [7:0]          cmd_arr [N_REQ];
  logic [DATA_W-1:0]   a_arr   [N_REQ];
  logic [DATA_W-1:0]   b_arr   [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign cmd_arr[gi] = req_cmd[gi*8 +: 8];
    assign a_arr[gi]   = req_a[gi*DATA_W +: DATA_W];
    assign b_arr[gi]   = req_b[gi*DATA_W +: DATA_W];
  end

  herald_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .grant_o      (pick_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      grant_q      <= '0;
      cmd_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      ack_q        <= '0;
      start_q      <= 1'b0;
      timer_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cmd_q        <= cmd_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ack_q        <= ack_d;
      start_q      <= start_d;
      timer_q      <= timer_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cmd_d        = cmd_q;
    a_d          = a_q;
    b_d          = b_q;
    ack_d        = '0;
    start_d      = 1'b0;
    timer_d      = timer_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d            = pick_grant;
          cmd_d              = cmd_arr[pick_grant];
          a_d                = a_arr[pick_grant];
          b_d                = b_arr[pick_grant];
          ack_d[pick_grant]  = 1'b1;
          if (is_legal_cmd(cmd_arr[pick_grant])) begin
            state_d = ISSUE;
          end else begin
            // Illegal codes answer straight away; the engine never sees them.
            rsp_valid_d[pick_grant] = 1'b1;
            rsp_err_d               = 1'b1;
            rsp_data_d              = '0;
            state_d                 = RESP;
          end
        end
      end
      ISSUE: begin
        start_d = 1'b1;
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_data_d           = eng_result;
          rsp_err_d            = 1'b0;
          state_d              = RESP;
        end else if (timer_q == TIMER_LAST) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_data_d           = '0;
          rsp_err_d            = 1'b1;
          state_d              = RESP;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d  = '0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ack   = ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign eng_start = start_q;
  assign eng_cmd   = cmd_q;
  assign eng_a     = a_q;
  assign eng_b     = b_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_herald_coproc_arbiter.sv
// Directed self-checking bench for herald_coproc_arbiter with a small
// engine model that returns done a programmable number of cycles after start.
module tb_herald_coproc_arbiter;

  localparam int N  = 2;
  localparam int DW = 24;
  localparam int RW = 72;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [8*N-1:0]  req_cmd;
  logic [DW*N-1:0] req_a, req_b;
  logic [N-1:0]    req_ack, rsp_valid, rsp_ready;
  logic [RW-1:0]   rsp_data;
  logic            rsp_err, eng_start, eng_done, busy;
  logic [7:0]      eng_cmd;
  logic [DW-1:0]   eng_a, eng_b;
  logic [RW-1:0]   eng_result;

  int n_checks = 0;
  int n_fail   = 0;
  int eng_delay;
  int eng_cnt;
  int start_cnt;
  logic stray_done;

  always #5 clk = ~clk;

  herald_coproc_arbiter #(
    .N_REQ(N), .DATA_W(DW), .RES_W(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_a(req_a),
    .req_b(req_b), .req_ack(req_ack), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_cmd(eng_cmd), .eng_a(eng_a), .eng_b(eng_b),
    .eng_done(eng_done), .eng_result(eng_result), .busy(busy)
  );

  // Engine model: delay 0 means the engine never answers.
  always @(posedge clk) begin
    if (rst) eng_cnt <= 0;
    else if (eng_start) eng_cnt <= eng_delay;
    else if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
  end
  assign eng_done = (eng_cnt == 1) || stray_done;

  always @(posedge clk) begin
    if (eng_start) start_cnt <= start_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command, checks its ack one cycle later, then drops req.
  task automatic issue(input int r, input logic [7:0] cmd, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input string tag);
    logic [N-1:0] exp_ack;
    exp_ack    = '0;
    exp_ack[r] = 1'b1;
    req_cmd[r*8 +: 8]  = cmd;
    req_a[r*DW +: DW]  = a;
    req_b[r*DW +: DW]  = b;
    req[r]             = 1'b1;
    tick();
    check({tag, "_ack"}, req_ack, exp_ack);
    req[r] = 1'b0;
    $display("txn %s: req%0d cmd=0x%0h a=0x%0h b=0x%0h", tag, r, cmd, a, b);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == '0 && n < 64) begin
      tick();
      n++;
    end
    if (rsp_valid == '0) check("rsp_wait", rsp_valid, 1);
  endtask

  task automatic finish_rsp(input int r, input string tag);
    rsp_ready[r] = 1'b1;
    tick();
    rsp_ready = '0;
    check({tag, "_idle"}, busy, 0);
    check({tag, "_valid_drop"}, rsp_valid, 0);
  endtask

  initial begin
    int n;
    int sc;
    int order[4];
    int nack;
    int multi;

    rst = 1'b1; req = '0; req_cmd = '0; req_a = '0; req_b = '0;
    rsp_ready = '0; eng_result = '0; eng_delay = 0; stray_done = 1'b0;
    start_cnt = 0;

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_ack", req_ack, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_start", eng_start, 0);
    check("rst_cmd", eng_cmd, 0);
    check("rst_data", rsp_data, 0);
    check("rst_err", rsp_err, 0);
    rst = 1'b0;
    tick();

    // Contention: both requesters held, grants must alternate from 0
    eng_delay = 2; eng_result = 72'h111;
    req_cmd = {8'h21, 8'h10}; req_a = '0; req_b = '0;
    rsp_ready = 2'b11; req = 2'b11;
    nack = 0; multi = 0;
    for (int c = 0; c < 200 && nack < 4; c++) begin
      tick();
      if ($countones(req_ack) > 1) multi++;
      if (req_ack != '0) begin
        order[nack] = req_ack[1] ? 1 : 0;
        $display("txn cont: grant%0d", order[nack]);
        nack++;
        if (nack == 4) req = '0;
      end
    end
    for (int c = 0; c < 50 && busy; c++) tick();
    rsp_ready = '0;
    check("cont_nack", nack, 4);
    check("cont_multi_ack", multi, 0);
    check("cont_g0", order[0], 0);
    check("cont_g1", order[1], 1);
    check("cont_g2", order[2], 0);
    check("cont_g3", order[3], 1);
    check("cont_idle", busy, 0);

    // Single request with timing
    eng_delay = 5; eng_result = 72'h002000;
    issue(0, 8'h20, 24'h001000, 24'h002000, "single");
    check("single_busy", busy, 1);
    check("single_cmd", eng_cmd, 8'h20);
    check("single_a", eng_a, 24'h001000);
    check("single_b", eng_b, 24'h002000);
    check("single_nostart_c1", eng_start, 0);
    tick();
    check("single_start_c2", eng_start, 1);
    check("single_ack_drop", req_ack, 0);
    wait_rsp(n);
    check("single_lat", n, 6);
    check("single_valid", rsp_valid, 2'b01);
    check("single_data", rsp_data, 72'h002000);
    check("single_err", rsp_err, 0);
    tick();
    check("single_hold_valid", rsp_valid, 2'b01);
    check("single_hold_data", rsp_data, 72'h002000);
    finish_rsp(0, "single");

    // Illegal command from requester 1
    sc = start_cnt;
    issue(1, 8'h7F, 24'h0, 24'h0, "illegal");
    check("illegal_valid", rsp_valid, 2'b10);
    check("illegal_err", rsp_err, 1);
    check("illegal_data", rsp_data, 0);
    rsp_ready = 2'b01;
    tick();
    check("illegal_other_ready_ignored", rsp_valid, 2'b10);
    rsp_ready = '0;
    finish_rsp(1, "illegal");
    check("illegal_no_start", start_cnt, sc);

    // Timeout, then stray done in RESP and IDLE, then a normal command
    eng_delay = 0; eng_result = 72'h0;
    issue(0, 8'h13, 24'h000123, 24'h000456, "timeout");
    tick();
    check("timeout_start", eng_start, 1);
    wait_rsp(n);
    check("timeout_lat", n, 16);
    check("timeout_err", rsp_err, 1);
    check("timeout_data", rsp_data, 0);
    stray_done = 1'b1; eng_result = 72'hDEAD_BEEF;
    tick();
    stray_done = 1'b0;
    check("stray_resp_data", rsp_data, 0);
    check("stray_resp_err", rsp_err, 1);
    check("stray_resp_valid", rsp_valid, 2'b01);
    finish_rsp(0, "timeout");
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    check("stray_idle_busy", busy, 0);
    check("stray_idle_valid", rsp_valid, 0);
    eng_delay = 3; eng_result = 72'h123456;
    issue(0, 8'h22, 24'h000001, 24'h000002, "after_to");
    wait_rsp(n);
    check("after_to_data", rsp_data, 72'h123456);
    check("after_to_err", rsp_err, 0);
    finish_rsp(0, "after_to");

    // Done in the same cycle the timer expires: done wins
    eng_delay = 15; eng_result = 72'hABCDEF_123456_654321;
    issue(1, 8'h12, 24'h000777, 24'h000888, "edge");
    tick();
    check("edge_start", eng_start, 1);
    wait_rsp(n);
    check("edge_lat", n, 16);
    check("edge_valid", rsp_valid, 2'b10);
    check("edge_err", rsp_err, 0);
    check("edge_data", rsp_data, 72'hABCDEF_123456_654321);
    finish_rsp(1, "edge");

    // Reset 3 cycles after eng_start
    eng_delay = 0;
    issue(1, 8'h11, 24'h00ABCD, 24'h001234, "rstwait");
    tick();
    check("rstwait_start", eng_start, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstwait_busy", busy, 0);
    check("rstwait_valid", rsp_valid, 0);
    check("rstwait_ack", req_ack, 0);
    check("rstwait_start0", eng_start, 0);
    check("rstwait_cmd", eng_cmd, 0);
    check("rstwait_a", eng_a, 0);
    check("rstwait_data", rsp_data, 0);
    check("rstwait_err", rsp_err, 0);
    sc = start_cnt;
    repeat (4) tick();
    check("rstwait_no_late_valid", rsp_valid, 0);
    check("rstwait_no_late_start", start_cnt, sc);
    eng_delay = 2; eng_result = 72'h55;
    req_cmd = {8'h23, 8'h21}; req = 2'b11;
    tick();
    check("rstwait_prio0", req_ack, 2'b01);
    req = '0;
    $display("txn rstwait_prio: grant from both requesting");
    wait_rsp(n);
    check("rstwait_prio_valid", rsp_valid, 2'b01);
    check("rstwait_prio_data", rsp_data, 72'h55);
    finish_rsp(0, "rstwait_prio");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
